// File: rtl/accel_spi_poller_if.sv
// SPI pin bundle between the accelerometer poller (master) and the sensor (slave).
interface accel_spi_poller_if;
    logic sclk;
    logic mosi;
    logic miso;
    logic cs;

    modport master (output sclk, output mosi, output cs, input miso);
    modport slave  (input sclk, input mosi, input cs, output miso);
endinterface

// File: rtl/accel_spi_poller.sv
// SPI mode-0 poller for an ADXL362-class accelerometer: one POWER_CTL write after
// startup, then periodic burst reads of NUM_AXES axis registers.
// Build option ACCEL_AVG_EN: publish a 4-sample running average per axis.
module accel_spi_poller #(
    parameter int CLK_DIV        = 2,
    parameter int NUM_AXES       = 2,
    parameter int SAMPLE_PERIOD  = 4000,
    parameter int STARTUP_CYCLES = 20000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    accel_spi_poller_if.master    spi,
    output logic [NUM_AXES*8-1:0] axis_data,
    output logic                  sample_valid,
    output logic [3:0]            tilt_code,
    output logic                  init_done,
    output logic                  busy
);
    localparam int INIT_BYTES = 3;
    localparam int READ_BYTES = 2 + NUM_AXES;
    localparam int HP_W  = $clog2(16*READ_BYTES + 2);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = $clog2(2*CLK_DIV + 1);
    localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
    localparam int ST_W  = $clog2(STARTUP_CYCLES + 1);
    localparam int RX_W  = NUM_AXES*8;

    typedef enum logic [1:0] {ST_STARTUP, ST_INIT, ST_IDLE, ST_READ} state_t;
    state_t state, state_nxt;

    logic [DIV_W-1:0] div_cnt;
    logic [HP_W-1:0]  hp;        // half-period index: 0 setup, 1..16B bits, 16B+1 hold
    logic [HP_W-1:0]  hp_last;
    logic [HP_W-1:0]  bit_k;     // bit index within the frame while hp is in 1..16B
    logic [GAP_W-1:0] gap_cnt;
    logic [PER_W-1:0] per_cnt;
    logic [ST_W-1:0]  st_cnt;
    logic [RX_W-1:0]  rx_sr;
    logic [7:0]       tx_byte;
    logic             in_frame, div_last, frame_end, in_bit, sample_now, go;
    logic             fin_init, fin_read;
    logic [NUM_AXES-1:0][7:0] raw, pub;

    function automatic logic [7:0] frame_byte(input logic is_init, input int idx);
        if (is_init) begin
            case (idx)
                0:       return 8'h0A;   // write command
                1:       return 8'h2D;   // POWER_CTL
                default: return 8'h02;   // measure mode
            endcase
        end else begin
            case (idx)
                0:       return 8'h0B;   // read command
                1:       return 8'h08;   // XDATA, auto-increments
                default: return 8'h00;   // dummy bytes clock out the axes
            endcase
        end
    endfunction

    // Frame decode: where we are in setup/bits/hold and what the pins should show
    always_comb begin
        in_frame   = (state == ST_INIT) || (state == ST_READ);
        hp_last    = (state == ST_INIT) ? HP_W'(16*INIT_BYTES + 1) : HP_W'(16*READ_BYTES + 1);
        div_last   = (div_cnt == DIV_W'(CLK_DIV - 1));
        frame_end  = in_frame && div_last && (hp == hp_last);
        bit_k      = (hp - HP_W'(1)) >> 1;
        in_bit     = in_frame && (hp != '0) && (hp != hp_last);
        tx_byte    = frame_byte(state == ST_INIT, int'(bit_k >> 3));
        sample_now = (state == ST_READ) && in_bit && !hp[0] && (div_cnt == '0) &&
                     (bit_k >= HP_W'(16));
        go         = (state == ST_IDLE) && enable &&
                     (per_cnt == PER_W'(SAMPLE_PERIOD - 1)) &&
                     (gap_cnt == GAP_W'(2*CLK_DIV - 1));
    end

    assign spi.cs   = !in_frame;
    assign spi.sclk = in_bit && !hp[0];
    assign spi.mosi = in_bit && tx_byte[~bit_k[2:0]];
    assign busy     = in_frame;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_STARTUP;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STARTUP: if (st_cnt == ST_W'(STARTUP_CYCLES - 1)) state_nxt = ST_INIT;
            ST_INIT:    if (frame_end) state_nxt = ST_IDLE;
            ST_IDLE:    if (go) state_nxt = ST_READ;
            ST_READ:    if (frame_end) state_nxt = ST_IDLE;
            default:    state_nxt = ST_STARTUP;
        endcase
    end

    // Bit timing: CLK_DIV cycles per half-period, hp walks through the frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            hp      <= '0;
        end else if (!in_frame || frame_end) begin
            div_cnt <= '0;
            hp      <= '0;
        end else if (div_last) begin
            div_cnt <= '0;
            hp      <= hp + HP_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Startup, period and cs-high gap counters; all saturate so a late tick is held
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_cnt  <= '0;
            per_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (state == ST_STARTUP && st_cnt != ST_W'(STARTUP_CYCLES - 1))
                st_cnt <= st_cnt + ST_W'(1);
            if (go)                                      per_cnt <= '0;
            else if (per_cnt != PER_W'(SAMPLE_PERIOD - 1)) per_cnt <= per_cnt + PER_W'(1);
            if (in_frame || go)                          gap_cnt <= '0;
            else if (gap_cnt != GAP_W'(2*CLK_DIV - 1))   gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

    // Shift MISO in during the dummy bytes; the first axis lands in the top byte
    always_ff @(posedge clock or posedge reset) begin
        if (reset)           rx_sr <= '0;
        else if (sample_now) rx_sr <= {rx_sr[RX_W-2:0], spi.miso};
    end

    // Frame completion flags, so outputs move one cycle after cs rises
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fin_init <= 1'b0;
            fin_read <= 1'b0;
        end else begin
            fin_init <= frame_end && (state == ST_INIT);
            fin_read <= frame_end && (state == ST_READ);
        end
    end

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_raw
        assign raw[a] = rx_sr[(NUM_AXES-1-a)*8 +: 8];
    end

`ifdef ACCEL_AVG_EN
    logic [NUM_AXES-1:0][2:0][7:0] hist;   // three previous samples, newest in [0]
    logic                          first_rd;

    function automatic logic signed [9:0] sx(input logic [7:0] v);
        return {{2{v[7]}}, v};
    endfunction

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_avg
        logic signed [9:0] sum;
        // First read after init counts as four copies of itself
        always_comb begin
            if (first_rd) sum = sx(raw[a]) <<< 2;
            else          sum = sx(raw[a]) + sx(hist[a][0]) + sx(hist[a][1]) + sx(hist[a][2]);
        end
        assign pub[a] = sum[9:2];
    end

    // History shift on each published sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist     <= '0;
            first_rd <= 1'b1;
        end else if (fin_read) begin
            first_rd <= 1'b0;
            for (int a = 0; a < NUM_AXES; a++) begin
                if (first_rd) hist[a] <= {3{raw[a]}};
                else          hist[a] <= {hist[a][1:0], raw[a]};
            end
        end
    end
`else
    assign pub = raw;
`endif

    // Published outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            axis_data    <= '0;
            tilt_code    <= 4'h8;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
        end else begin
            sample_valid <= fin_read;
            if (fin_init) init_done <= 1'b1;
            if (fin_read) begin
                axis_data <= pub;
                tilt_code <= {~pub[0][7], pub[0][6:4]};
            end
        end
    end
endmodule

// File: tb/tb_accel_spi_poller.sv
// Bench for accel_spi_poller: sensor model on MISO, MOSI byte capture, cs timing
// monitors, and a reference model of the published sample and tilt code.
module tb_accel_spi_poller;
    localparam int CLK_DIV  = 2;
    localparam int NUM_AXES = 2;
    localparam int STARTUP  = 10;
    localparam int PERIOD   = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] axis_data, axis_data_f;
    logic        sample_valid, sample_valid_f, init_done, init_done_f, busy, busy_f;
    logic [3:0]  tilt_code, tilt_code_f;

    accel_spi_poller_if spi ();
    accel_spi_poller_if spi_f ();

    always #5 clock = ~clock;

    accel_spi_poller #(.CLK_DIV(CLK_DIV), .NUM_AXES(NUM_AXES), .SAMPLE_PERIOD(PERIOD),
                       .STARTUP_CYCLES(STARTUP)) dut (
        .clock(clock), .reset(reset), .enable(enable), .spi(spi),
        .axis_data(axis_data), .sample_valid(sample_valid), .tilt_code(tilt_code),
        .init_done(init_done), .busy(busy));

    accel_spi_poller #(.CLK_DIV(CLK_DIV), .NUM_AXES(NUM_AXES), .SAMPLE_PERIOD(10),
                       .STARTUP_CYCLES(STARTUP)) dut_f (
        .clock(clock), .reset(reset), .enable(enable), .spi(spi_f),
        .axis_data(axis_data_f), .sample_valid(sample_valid_f), .tilt_code(tilt_code_f),
        .init_done(init_done_f), .busy(busy_f));

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // ---------------- sensor model: serves axis bytes after the two command bytes
    logic [7:0] sens [NUM_AXES];
    int         miso_idx = 0;
    logic       miso_r = 1'b0;

    function automatic logic miso_bit(input int idx);
        int j;
        if (idx < 16 || idx >= 16 + 8*NUM_AXES) return 1'b0;
        j = idx - 16;
        return sens[j/8][7 - (j%8)];
    endfunction

    always @(negedge spi.sclk or posedge spi.cs) begin
        if (spi.cs) miso_idx = 0;
        else        miso_idx++;
        miso_r = miso_bit(miso_idx);
    end
    assign spi.miso   = miso_r;
    assign spi_f.miso = 1'b0;

    // ---------------- MOSI capture at each sclk rise, cleared at cs fall
    logic mosi_q [$];
    always @(posedge spi.sclk or negedge spi.cs) begin
        if (!spi.sclk) mosi_q.delete();
        else           mosi_q.push_back(spi.mosi);
    end

    function automatic logic [31:0] mosi_word();
        logic [31:0] w = '0;
        foreach (mosi_q[i]) w = {w[30:0], mosi_q[i]};
        return w;
    endfunction

    // ---------------- cs timing monitors
    int   cyc = 0, falls = 0, last_fall = 0, prev_fall = 0, low_cnt = 0, low_len = 0;
    int   hold_viol = 0, sv_cnt = 0;
    logic prev_cs = 1'b1, prev_mosi = 1'b0;
    int   f_high = 0, f_gap = 0, f_falls = 0, f_low = 0, f_low_len = 0;
    logic f_prev_cs = 1'b1;

    always @(negedge clock) begin
        cyc++;
        if (prev_cs && !spi.cs) begin
            falls++; prev_fall = last_fall; last_fall = cyc; low_cnt = 0;
        end
        if (!spi.cs) low_cnt++;
        if (!prev_cs && spi.cs) low_len = low_cnt;
        if (spi.sclk && spi.mosi !== prev_mosi) hold_viol++;
        if (sample_valid) sv_cnt++;
        prev_cs = spi.cs;
        prev_mosi = spi.mosi;
        if (f_prev_cs && !spi_f.cs) begin f_falls++; f_gap = f_high; f_low = 0; end
        if (spi_f.cs) f_high++; else begin f_high = 0; f_low++; end
        if (!f_prev_cs && spi_f.cs) f_low_len = f_low;
        f_prev_cs = spi_f.cs;
    end

    // ---------------- reference model of published samples
`ifdef ACCEL_AVG_EN
    int hist [NUM_AXES][4];
    bit hist_empty = 1'b1;
`endif

    task automatic model_publish(output logic [31:0] ea, output logic [31:0] et);
        int v [NUM_AXES];
        int s;
`ifdef ACCEL_AVG_EN
        int sum;
`endif
        ea = '0;
        for (int a = 0; a < NUM_AXES; a++) begin
            s = int'(sens[a]);
            if (s > 127) s -= 256;
`ifdef ACCEL_AVG_EN
            if (hist_empty) for (int k = 0; k < 4; k++) hist[a][k] = s;
            else begin
                for (int k = 3; k > 0; k--) hist[a][k] = hist[a][k-1];
                hist[a][0] = s;
            end
            sum = hist[a][0] + hist[a][1] + hist[a][2] + hist[a][3];
            v[a] = sum >>> 2;
`else
            v[a] = s;
`endif
            ea = ea | 32'((v[a] & 255) << (8*a));
        end
`ifdef ACCEL_AVG_EN
        hist_empty = 1'b0;
`endif
        et = 32'((v[0] + 128) >> 4);
    endtask

    task automatic wait_cs(input logic lvl, input int bound, output bit ok);
        int n = 0;
        while (spi.cs !== lvl && n < bound) begin tick(); n++; end
        ok = (spi.cs === lvl);
    endtask

    task automatic init_frame(input string tag);
        int n = 0;
        bit ok;
        while (spi.cs === 1'b1 && n < 50) begin tick(); n++; end
        check({tag, "_startup_cycles"}, 32'(n), STARTUP);
        wait_cs(1'b1, 300, ok);
        check({tag, "_init_timeout"}, 32'(ok), 1);
        check({tag, "_init_cs_low"}, 32'(low_len), CLK_DIV*(2 + 16*3));
        check({tag, "_init_bits"}, 32'(mosi_q.size()), 24);
        check({tag, "_init_bytes"}, mosi_word(), 32'h000A2D02);
        check({tag, "_init_done_at_rise"}, 32'(init_done), 0);
        tick();
        check({tag, "_init_done_after"}, 32'(init_done), 1);
    endtask

    task automatic read_frame(input string tag);
        logic [31:0] ea, et;
        bit ok;
        wait_cs(1'b0, 3*PERIOD, ok);
        check({tag, "_fall_timeout"}, 32'(ok), 1);
        wait_cs(1'b1, 3*PERIOD, ok);
        check({tag, "_rise_timeout"}, 32'(ok), 1);
        check({tag, "_cs_low"}, 32'(low_len), CLK_DIV*(2 + 16*(2 + NUM_AXES)));
        check({tag, "_cmd_bytes"}, mosi_word(), 32'h0B080000);
        check({tag, "_valid_at_rise"}, 32'(sample_valid), 0);
        model_publish(ea, et);
        tick();
        check({tag, "_valid"}, 32'(sample_valid), 1);
        check({tag, "_axis"}, 32'(axis_data), ea);
        check({tag, "_tilt"}, 32'(tilt_code), et);
        tick();
        check({tag, "_valid_one_cycle"}, 32'(sample_valid), 0);
    endtask

    logic [7:0] dir_x [6] = '{8'h40, 8'h80, 8'h10, 8'h20, 8'h30, 8'h40};
    logic [7:0] dir_y [6] = '{8'hC0, 8'h7F, 8'h01, 8'hFE, 8'h55, 8'hAA};

    initial begin
        int n0, s0;
        bit ok;
        sens[0] = 8'h00;
        sens[1] = 8'h00;
        repeat (3) tick();
        check("rst_cs", 32'(spi.cs), 1);
        check("rst_sclk", 32'(spi.sclk), 0);
        check("rst_mosi", 32'(spi.mosi), 0);
        check("rst_axis", 32'(axis_data), 0);
        check("rst_tilt", 32'(tilt_code), 4'h8);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cs_fast", 32'(spi_f.cs), 1);

        reset = 1'b0;
        init_frame("boot");

        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 6) begin sens[0] = dir_x[i]; sens[1] = dir_y[i]; end
            else begin
                sens[0] = 8'($urandom_range(0, 255));
                sens[1] = 8'($urandom_range(0, 255));
            end
            read_frame($sformatf("rd%0d", i));
            if (i > 0) check($sformatf("rd%0d_period", i), 32'(last_fall - prev_fall), PERIOD);
        end
        check("fast_frames", 32'(f_falls >= 3), 1);
        check("fast_gap", 32'(f_gap), 2*CLK_DIV);
        check("fast_cs_low", 32'(f_low_len), CLK_DIV*(2 + 16*(2 + NUM_AXES)));

        // enable drops mid-frame: frame still completes and publishes, then silence
        sens[0] = 8'h9C;
        sens[1] = 8'h3E;
        wait_cs(1'b0, 3*PERIOD, ok);
        check("en_off_fall_timeout", 32'(ok), 1);
        repeat (20) tick();
        enable = 1'b0;
        begin
            logic [31:0] ea, et;
            wait_cs(1'b1, 3*PERIOD, ok);
            check("en_off_rise_timeout", 32'(ok), 1);
            check("en_off_cs_low", 32'(low_len), CLK_DIV*(2 + 16*(2 + NUM_AXES)));
            model_publish(ea, et);
            tick();
            check("en_off_valid", 32'(sample_valid), 1);
            check("en_off_axis", 32'(axis_data), ea);
        end
        n0 = falls;
        repeat (2*PERIOD + 50) tick();
        check("en_off_no_frames", 32'(falls), 32'(n0));
        check("en_off_cs_high", 32'(spi.cs), 1);

        // reset during bit 5 of a read aborts without any update
        enable = 1'b1;
        sens[0] = 8'h11;
        sens[1] = 8'h22;
        wait_cs(1'b0, 3*PERIOD, ok);
        check("abort_fall_timeout", 32'(ok), 1);
        n0 = 0;
        while (mosi_q.size() < 6 && n0 < 200) begin tick(); n0++; end
        check("abort_reach_bit5", 32'(mosi_q.size()), 6);
        check("abort_busy", 32'(busy), 1);
        s0 = sv_cnt;
        #2 reset = 1'b1;
        #1;
        check("abort_cs", 32'(spi.cs), 1);
        check("abort_sclk", 32'(spi.sclk), 0);
        check("abort_axis", 32'(axis_data), 0);
        check("abort_tilt", 32'(tilt_code), 4'h8);
        check("abort_init_done", 32'(init_done), 0);
        repeat (3) tick();
`ifdef ACCEL_AVG_EN
        hist_empty = 1'b1;
`endif
        reset = 1'b0;
        init_frame("rerun");
        check("abort_no_valid", 32'(sv_cnt), 32'(s0));
        sens[0] = 8'h80;
        sens[1] = 8'h7F;
        read_frame("post_abort");

        check("mosi_stable_sclk_high", 32'(hold_viol), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
